// File: rtl/ide_pio_fifo.sv
// ide_pio_fifo: 16-bit host / 8-bit MCU PIO data FIFO with block counting, DRQ and under/overrun flags.
// Optional macro IDE_PIO_IRQ_EN adds a latched MCU interrupt. Rev 1.0
`default_nettype none

module ide_pio_fifo #(
  parameter int DEPTH_LOG2 = 4,
  parameter int CNT_W      = 16
) (
  input  logic        clk,
  input  logic        reset_,
  input  logic        host_rd,
  input  logic        host_wr,
  input  logic [15:0] host_wdata,
  output logic [15:0] host_rdata,
  output logic        drq,
  input  logic [1:0]  sram_a,
  input  logic [7:0]  sram_d_in,
  output logic [7:0]  sram_d_out,
  input  logic        sram_cs,
  input  logic        sram_oe,
  input  logic        sram_we,
  output logic        mcu_irq
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int LW    = DEPTH_LOG2 + 1;
  localparam logic [DEPTH_LOG2:0] LEVEL_FULL = LW'(DEPTH);

  logic [15:0]           mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr, rd_ptr;
  logic [DEPTH_LOG2:0]   level;
  logic [CNT_W-1:0]      remaining, load_val;
  logic                  active, dir, done, ovr, unr, byte_phase;
  logic [7:0]            low_byte;
  logic                  we_d, oe_d;

  logic mcu_wr, mcu_rd, ctrl_wr, data_wr, data_rd;
  logic flush, start, clr;
  logic empty, full;
  logic pop_host, pop_mcu, pop, push_req, push;
  logic ovr_set, unr_set, xfer, last, done_set;
  logic [15:0] push_data, head, load_ext, rem_ext;
  logic [7:0]  status, data_byte;

  // Each MCU access acts once, on the first cycle its strobe combination is seen.
  assign mcu_wr  = sram_cs & sram_we & ~we_d;
  assign mcu_rd  = sram_cs & sram_oe & ~oe_d;
  assign ctrl_wr = mcu_wr & (sram_a == 2'd1);
  assign data_wr = mcu_wr & (sram_a == 2'd0);
  assign data_rd = mcu_rd & (sram_a == 2'd0);

  assign flush = ctrl_wr & sram_d_in[2];
  assign start = ctrl_wr & sram_d_in[1] & ~sram_d_in[2];
  assign clr   = ctrl_wr & sram_d_in[3];

  assign empty = (level == '0);
  assign full  = (level == LEVEL_FULL);

  assign pop_host = ~flush & active & ~dir & host_rd & ~empty;
  assign pop_mcu  = ~flush & dir & data_rd & byte_phase & ~empty;
  assign pop      = pop_host | pop_mcu;
  assign push_req = ~flush & ((~dir & data_wr & byte_phase) | (active & dir & host_wr));
  // A pop on the same edge frees a slot, so a push into a full FIFO still lands.
  assign push     = push_req & (~full | pop);
  assign ovr_set  = push_req & full & ~pop;
  assign unr_set  = ~flush & active & ~dir & host_rd & empty;
  assign xfer     = pop_host | (push & dir);
  assign last     = xfer & (remaining == CNT_W'(1));
  assign done_set = start ? (load_val == '0) : last;

  assign push_data = dir ? host_wdata : {sram_d_in, low_byte};
  assign head      = mem[rd_ptr];
  assign load_ext  = 16'(load_val);
  assign rem_ext   = 16'(remaining);

  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      we_d       <= 1'b0;
      oe_d       <= 1'b0;
      low_byte   <= 8'h00;
      load_val   <= '0;
      remaining  <= '0;
      dir        <= 1'b0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      level      <= '0;
      byte_phase <= 1'b0;
      active     <= 1'b0;
      done       <= 1'b0;
      ovr        <= 1'b0;
      unr        <= 1'b0;
    end else begin
      we_d <= sram_cs & sram_we;
      oe_d <= sram_cs & sram_oe;
      if (data_wr && !dir && !byte_phase) low_byte <= sram_d_in;
      if (mcu_wr && sram_a == 2'd2) load_val <= CNT_W'({load_ext[15:8], sram_d_in});
      if (mcu_wr && sram_a == 2'd3) load_val <= CNT_W'({sram_d_in, load_ext[7:0]});

      if (flush) begin
        wr_ptr     <= '0;
        rd_ptr     <= '0;
        level      <= '0;
        byte_phase <= 1'b0;
        active     <= 1'b0;
        done       <= 1'b0;
        ovr        <= 1'b0;
        unr        <= 1'b0;
      end else begin
        if (push) wr_ptr <= wr_ptr + DEPTH_LOG2'(1);
        if (pop)  rd_ptr <= rd_ptr + DEPTH_LOG2'(1);
        if (push && !pop)      level <= level + LW'(1);
        else if (pop && !push) level <= level - LW'(1);
        if ((!dir && data_wr) || (dir && data_rd && !empty)) byte_phase <= ~byte_phase;
        ovr  <= ovr_set | (ovr & ~clr);
        unr  <= unr_set | (unr & ~clr);
        done <= done_set | (done & ~clr & ~start);
        if (start) begin
          dir       <= sram_d_in[0];
          remaining <= load_val;
          active    <= (load_val != '0);
        end else if (xfer) begin
          remaining <= remaining - CNT_W'(1);
          if (last) active <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      drq        <= 1'b0;
      host_rdata <= 16'h0000;
    end else begin
      drq <= active & (dir ? ~full : ~empty);
      if (!empty) host_rdata <= head;
    end
  end

  assign status    = {active, dir, done, ovr, unr, full, empty, byte_phase};
  assign data_byte = empty ? 8'h00 : (byte_phase ? head[15:8] : head[7:0]);

  always_comb begin
    sram_d_out = 8'h00;
    case (sram_a)
      2'd0:    sram_d_out = data_byte;
      2'd1:    sram_d_out = status;
      2'd2:    sram_d_out = rem_ext[7:0];
      default: sram_d_out = rem_ext[15:8];
    endcase
  end

`ifdef IDE_PIO_IRQ_EN
  logic irq;
  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_)                             irq <= 1'b0;
    else if (ovr_set || unr_set || done_set) irq <= 1'b1;
    else if (clr || flush)                   irq <= 1'b0;
  end
  assign mcu_irq = irq;
`else
  assign mcu_irq = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_ide_pio_fifo.sv
// tb_ide_pio_fifo: directed and random checks of ide_pio_fifo against a queue-based reference model.
`default_nettype none

module tb_ide_pio_fifo;
  localparam int DL    = 2;
  localparam int DEPTH = 1 << DL;

  logic        clk = 1'b0;
  logic        reset_ = 1'b0;
  logic        host_rd = 1'b0, host_wr = 1'b0;
  logic [15:0] host_wdata = 16'h0000;
  logic [15:0] host_rdata;
  logic        drq;
  logic [1:0]  sram_a = 2'd0;
  logic [7:0]  sram_d_in = 8'h00;
  logic [7:0]  sram_d_out;
  logic        sram_cs = 1'b0, sram_oe = 1'b0, sram_we = 1'b0;
  logic        mcu_irq;

  always #5 clk = ~clk;

  ide_pio_fifo #(.DEPTH_LOG2(DL), .CNT_W(16)) dut (
    .clk(clk), .reset_(reset_),
    .host_rd(host_rd), .host_wr(host_wr), .host_wdata(host_wdata), .host_rdata(host_rdata),
    .drq(drq),
    .sram_a(sram_a), .sram_d_in(sram_d_in), .sram_d_out(sram_d_out),
    .sram_cs(sram_cs), .sram_oe(sram_oe), .sram_we(sram_we),
    .mcu_irq(mcu_irq)
  );

  int cmp_cnt = 0;
  int err_cnt = 0;

  // Reference model: transfer state kept as plain variables and a word queue.
  logic [15:0] q[$];
  logic [15:0] rem, load, m_head;
  logic [7:0]  m_low;
  bit          m_active, m_dir, m_done, m_ovr, m_unr, m_bp, m_irq;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    cmp_cnt++;
    assert (obs === exp) else begin
      err_cnt++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic void m_reset();
    q.delete();
    rem = 0; load = 0; m_head = 0; m_low = 0;
    m_active = 0; m_dir = 0; m_done = 0; m_ovr = 0; m_unr = 0; m_bp = 0; m_irq = 0;
  endfunction

  function automatic void m_settle();
    if (q.size() != 0) m_head = q[0];
  endfunction

  function automatic logic [7:0] m_status();
    return {m_active, m_dir, m_done, m_ovr, m_unr, q.size() == DEPTH, q.size() == 0, m_bp};
  endfunction

  function automatic logic m_irq_exp();
`ifdef IDE_PIO_IRQ_EN
    return m_irq;
`else
    return 1'b0;
`endif
  endfunction

  function automatic void m_word_done();
    rem = rem - 16'd1;
    if (rem == 0) begin m_active = 0; m_done = 1; m_irq = 1; end
  endfunction

  function automatic void m_ctrl(input logic [7:0] v);
    if (v[2]) begin
      q.delete();
      m_bp = 0; m_active = 0; m_done = 0; m_ovr = 0; m_unr = 0; m_irq = 0;
    end else begin
      if (v[3]) begin m_ovr = 0; m_unr = 0; m_done = 0; m_irq = 0; end
      if (v[1]) begin
        m_dir = v[0]; rem = load;
        m_active = (load != 0); m_done = (load == 0);
        if (load == 0) m_irq = 1;
      end
    end
  endfunction

  task automatic mcu_wr(input logic [1:0] a, input logic [7:0] d);
    @(posedge clk); #1;
    sram_a = a; sram_d_in = d; sram_cs = 1; sram_we = 1;
    @(posedge clk); #1;
    sram_cs = 0; sram_we = 0;
  endtask

  task automatic mcu_rd(input logic [1:0] a, output logic [7:0] d);
    @(posedge clk); #1;
    sram_a = a; sram_cs = 1; sram_oe = 1;
    #2 d = sram_d_out;
    @(posedge clk); #1;
    sram_cs = 0; sram_oe = 0;
  endtask

  task automatic do_ctrl(input logic [7:0] v);
    mcu_wr(2'd1, v); m_ctrl(v); m_settle();
  endtask

  task automatic do_cnt(input logic [15:0] v);
    mcu_wr(2'd2, v[7:0]); mcu_wr(2'd3, v[15:8]); load = v;
  endtask

  task automatic do_data_wr(input logic [7:0] b);
    mcu_wr(2'd0, b);
    if (!m_dir) begin
      if (!m_bp) begin m_low = b; m_bp = 1; end
      else begin
        m_bp = 0;
        if (q.size() < DEPTH) q.push_back({b, m_low});
        else begin m_ovr = 1; m_irq = 1; end
      end
    end
    m_settle();
  endtask

  task automatic do_data_rd(input string tag);
    logic [7:0] d, e;
    e = (q.size() == 0) ? 8'h00 : (m_bp ? q[0][15:8] : q[0][7:0]);
    mcu_rd(2'd0, d);
    chk(tag, d, e);
    if (m_dir && q.size() != 0) begin
      if (!m_bp) m_bp = 1;
      else begin m_bp = 0; void'(q.pop_front()); end
    end
    m_settle();
  endtask

  task automatic do_host_wr(input logic [15:0] w);
    @(posedge clk); #1;
    host_wr = 1; host_wdata = w;
    @(posedge clk); #1;
    host_wr = 0;
    if (m_active && m_dir) begin
      if (q.size() < DEPTH) begin q.push_back(w); m_word_done(); end
      else begin m_ovr = 1; m_irq = 1; end
    end
    m_settle();
  endtask

  task automatic do_host_rd(input string tag);
    @(posedge clk); #1;
    chk(tag, host_rdata, m_head);
    host_rd = 1;
    @(posedge clk); #1;
    host_rd = 0;
    if (m_active && !m_dir) begin
      if (q.size() != 0) begin void'(q.pop_front()); m_word_done(); end
      else begin m_unr = 1; m_irq = 1; end
    end
    m_settle();
  endtask

  task automatic check_all(input string tag);
    @(posedge clk); #1;
    sram_a = 2'd1;
    #1;
    chk({tag, ".status"}, sram_d_out, m_status());
    chk({tag, ".drq"}, drq, m_active & (m_dir ? (q.size() != DEPTH) : (q.size() != 0)));
    chk({tag, ".rdata"}, host_rdata, m_head);
    chk({tag, ".irq"}, mcu_irq, m_irq_exp());
  endtask

  task automatic check_cnt(input string tag);
    logic [7:0] lo, hi;
    mcu_rd(2'd2, lo);
    mcu_rd(3'd3, hi);
    chk(tag, {hi, lo}, rem);
  endtask

  initial begin
    int r;
    m_reset();
    repeat (3) @(posedge clk);
    #3 reset_ = 1'b1;
    check_all("reset");
    check_cnt("reset.cnt");

    // Asynchronous reset in the middle of a full device->host transfer.
    do_cnt(16'd8); do_ctrl(8'h02);
    for (int i = 0; i < 8; i++) do_data_wr(8'(8'h10 + i));
    check_all("prefill");
    chk("prefill.status_lit", sram_d_out, 8'h84);
    @(posedge clk); #3;
    sram_a = 2'd1;
    reset_ = 1'b0;
    #1;
    chk("async.drq", drq, 1'b0);
    chk("async.rdata", host_rdata, 16'h0000);
    chk("async.status", sram_d_out, 8'h02);
    chk("async.irq", mcu_irq, 1'b0);
    repeat (2) @(posedge clk);
    #3 reset_ = 1'b1;
    m_reset();
    check_all("post_reset");
    check_cnt("post_reset.cnt");

    // Device->host: two words, DRQ latency, then completion.
    do_cnt(16'd2); do_ctrl(8'h02);
    do_data_wr(8'h34); do_data_wr(8'h12);
    chk("d2h.drq_early", drq, 1'b0);
    @(posedge clk); #1;
    chk("d2h.drq_late", drq, 1'b1);
    chk("d2h.rdata0", host_rdata, 16'h1234);
    do_data_wr(8'h78); do_data_wr(8'h56);
    do_host_rd("d2h.rd0");
    check_all("d2h.mid");
    chk("d2h.rdata1", host_rdata, 16'h5678);
    do_host_rd("d2h.rd1");
    check_all("d2h.end");
    chk("d2h.status_lit", sram_d_out, 8'h22);
    check_cnt("d2h.cnt");

    // Host->device: three words, drained bytewise by the MCU.
    do_ctrl(8'h04);
    do_cnt(16'd3); do_ctrl(8'h03);
    do_host_wr(16'hBEEF); do_host_wr(16'hCAFE); do_host_wr(16'h0001);
    check_all("h2d.done");
    chk("h2d.status_lit", sram_d_out, 8'h60);
    for (int i = 0; i < 7; i++) do_data_rd($sformatf("h2d.byte%0d", i));
    check_all("h2d.drained");
    chk("h2d.empty_lit", sram_d_out, 8'h62);

    // Host->device overrun into a 4-word FIFO.
    do_ctrl(8'h04);
    do_cnt(16'd10); do_ctrl(8'h03);
    for (int i = 0; i < 6; i++) do_host_wr(16'(16'hA000 + i));
    check_all("ovr");
    chk("ovr.status_lit", sram_d_out, 8'hD4);
    check_cnt("ovr.cnt");

    // Underrun on an empty FIFO, then flag clear.
    do_ctrl(8'h04);
    do_cnt(16'd1); do_ctrl(8'h02);
    do_host_rd("unr.rd");
    check_all("unr");
    chk("unr.status_lit", sram_d_out, 8'h8A);
    check_cnt("unr.cnt");
    do_ctrl(8'h08);
    check_all("unr.clr");

    // Zero-length start, then flush taking priority over start.
    do_cnt(16'd0); do_ctrl(8'h02);
    check_all("zero");
    chk("zero.status_lit", sram_d_out, 8'h22);
    do_cnt(16'd5); do_ctrl(8'h06);
    check_all("flush_start");
    chk("flush_start.status_lit", sram_d_out, 8'h02);

    // Random operation mix against the model.
    for (int n = 0; n < 400; n++) begin
      r = int'($urandom_range(0, 99));
      if (r < 20)      do_data_wr(8'($urandom));
      else if (r < 35) do_data_rd("rnd.byte");
      else if (r < 55) do_host_wr(16'($urandom));
      else if (r < 75) do_host_rd("rnd.rd");
      else if (r < 85) do_cnt(16'($urandom_range(0, 9)));
      else if (r < 93) do_ctrl({4'b0000, 1'($urandom), 1'b0, 1'b1, 1'($urandom)});
      else if (r < 97) do_ctrl(8'h08);
      else             do_ctrl({5'b00000, 1'b1, 1'($urandom), 1'b0});
      check_all("rnd");
      if (n % 8 == 0) check_cnt("rnd.cnt");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

endmodule

`default_nettype wire
